ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Sequences the configuration-chain flip-flops (ccff_head -> ... -> ccff_tail) of a tile column on prog_clk.
//  Accepts bitstream words over a valid/ready port, serialises them LSB-first onto ccff_head and gates shifting with ccff_shift_en.
//  Stops after exactly CHAIN_LEN shifts and signals done.
//  Sits between the SoC-side bitstream source and the head of the grid_io/CLB configuration chain.
// PARAMETERS
//  CHAIN_LEN  64  number of ccff bits in the chain (>=1)
//  WORD_W     8   bitstream word width (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)  localparam, shift-counter width
// PORTS
//  prog_clk       in   1       programming clock; all state on rising edge
//  prog_rst_n     in   1       synchronous active-low reset
//  start          in   1       begin a load; sampled only in IDLE
//  cfg_wdata      in   WORD_W  bitstream word, bit 0 shifted first
//  cfg_wvalid     in   1       cfg_wdata valid
//  cfg_wready     out  1       loader can accept a word this cycle
//  ccff_head      out  1       serial data to chain head
//  ccff_shift_en  out  1       chain shifts on this prog_clk edge
//  ccff_tail      in   1       serial data from chain tail
//  busy           out  1       high in any state except IDLE
//  done           out  1       one-cycle pulse when load (and check) completes
//  error          out  1       sticky readback mismatch; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; cfg_wready, ccff_head, ccff_shift_en, busy, done, error = 0; counters 0. Chain contents undefined after mid-load reset.
//  FSM IDLE -> LOAD on start. Counters clear; error clears.
//  LOAD: cfg_wready=1. On valid&ready, capture word into shreg; word_bits=WORD_W; -> SHIFT.
//  SHIFT: cfg_wready=0, ccff_shift_en=1, ccff_head=shreg[0]. Each cycle: shreg>>=1, word_bits--, bit_cnt++.
//  Exit SHIFT when bit_cnt reaches CHAIN_LEN: -> CHECK (macro on) or DONE. Unshifted bits of a partial final word are discarded.
//  Otherwise, when word_bits reaches 0: -> LOAD.
//  Rate: one idle (LOAD) cycle per word minimum. cfg_wvalid low in LOAD stalls with ccff_shift_en=0; no bit is lost or duplicated.
//  DONE: done=1 for one cycle, busy=1; -> IDLE. start in any non-IDLE state is ignored.
//  First bit shifted in reaches ccff_tail after CHAIN_LEN shifts. ccff_shift_en is never high outside SHIFT/CHECK.
// CONFIGURATION
//  Macro CCFF_READBACK_CHECK_EN.
//  Defined: serial CRC-16 (poly 0x1021, init 0xFFFF) runs over every ccff_head bit in SHIFT. CHECK then shifts CHAIN_LEN more cycles with ccff_head=ccff_tail (recirculation: net rotation = identity, configuration preserved) and runs a second CRC over ccff_tail. At the end, error |= (crc_in != crc_out); -> DONE. done and error are valid in the same cycle.
//  Undefined: no CHECK state and no CRC logic; error tied 0; SHIFT -> DONE directly.
// STRUCTURE
//  Package ccff_loader_pkg: state enum (IDLE, LOAD, SHIFT, CHECK, DONE); CRC16_POLY, CRC16_INIT constants; crc16_step(crc,bit) function.
//  Sub-module ccff_crc16_serial (clr, en, bit_in, crc_out). Instantiated twice under the macro.
// TESTING
//  T1 CHAIN_LEN=16, WORD_W=8, words 0xA5,0x3C: ccff_head on shift cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Exactly 16 ccff_shift_en cycles; one done pulse.
//  T2 CHAIN_LEN=12, words 0xFF,0x0F: 12 shifts, second word's bits 4..7 never driven. cfg_wready stays 0 after the second accept; done asserts.
//  T3 backpressure: cfg_wvalid low 5 cycles between words -> ccff_shift_en low throughout gap; chain model holds 0xA5,0x3C intact.
//  T4 start pulsed during SHIFT -> ignored: bit count and done timing identical to T1.
//  T5 prog_rst_n low mid-SHIFT (bit 5) -> next edge: IDLE, all outputs 0. A new start reloads the full chain correctly.
//  T6 (macro on) 16-bit ideal chain model -> error=0, chain contents unchanged after CHECK. Model with bit 7 stuck-at-0 and data 0xFF,0xFF -> error=1 with done.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and helpers for the configuration-chain loader.
//   state_t      : loader FSM states (IDLE, LOAD, SHIFT, CHECK, DONE)
//   CRC16_POLY   : CRC-16 polynomial 0x1021 (x^16 + x^12 + x^5 + 1)
//   CRC16_INIT   : CRC-16 seed value 0xFFFF
//   crc16_step() : advance a serial CRC-16 by one input bit
// Optional feature macro used by the loader: CCFF_READBACK_CHECK_EN.
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first serial CRC: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ----------------------------------------------------------------------------
// ccff_crc16_serial
// Bit-serial CRC-16 accumulator used for configuration readback checking.
// Only present when CCFF_READBACK_CHECK_EN is defined.
// Ports:
//   clk      in   clock (rising edge)
//   rst_n    in   synchronous active-low reset (loads CRC16_INIT)
//   clr      in   reload CRC16_INIT on this edge (has priority over en)
//   en       in   absorb bit_in on this edge
//   bit_in   in   serial data bit
//   crc_out  out  current CRC register value
// ----------------------------------------------------------------------------
`ifdef CCFF_READBACK_CHECK_EN
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            crc_out <= CRC16_INIT;
        end else if (en) begin
            crc_out <= crc16_step(crc_out, bit_in);
        end
    end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
// Loads a tile-column configuration chain (ccff_head -> ... -> ccff_tail).
// Bitstream words arrive on a valid/ready port and are shifted LSB-first onto
// ccff_head, one bit per prog_clk with ccff_shift_en high, until exactly
// CHAIN_LEN bits have been shifted; then done pulses for one cycle.
//
// Handshake: a word transfers on a rising edge where cfg_wvalid && cfg_wready.
// cfg_wready is high only in LOAD and does not depend on cfg_wvalid.
//
// Optional feature (macro CCFF_READBACK_CHECK_EN): after loading, the chain
// is rotated CHAIN_LEN more times with ccff_head fed from ccff_tail, and a
// CRC-16 of the shifted-in bits is compared with a CRC-16 of the bits seen at
// ccff_tail. A mismatch sets the sticky error flag. Without the macro there
// is no CHECK phase and error is tied low.
//
// Ports:
//   prog_clk       in   programming clock, all state on rising edge
//   prog_rst_n     in   synchronous active-low reset
//   start          in   begin a load (sampled only in IDLE)
//   cfg_wdata      in   bitstream word, bit 0 shifted first
//   cfg_wvalid     in   cfg_wdata valid
//   cfg_wready     out  loader accepts a word this cycle
//   ccff_head      out  serial data to chain head
//   ccff_shift_en  out  chain shifts on this edge
//   ccff_tail      in   serial data from chain tail
//   busy           out  high in every state except IDLE
//   done           out  one-cycle completion pulse
//   error          out  sticky readback mismatch, cleared on accepted start
//   dbg_state      out  current FSM state (state_t encoding)
// ----------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_wdata,
    input  logic              cfg_wvalid,
    output logic              cfg_wready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);
    localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(WORD_W);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   word_bits;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;
    logic              start_acc;

    // bit_cnt counts shifts of the current phase; it wraps to 0 on the last
    // shift of SHIFT so the CHECK rotation can reuse it.
    assign last_bit  = (bit_cnt == LAST_CNT);
    assign start_acc = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (cfg_wvalid) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
`ifdef CCFF_READBACK_CHECK_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end else if (word_bits == WB_ONE) begin
                    state_nxt = LOAD;
                end
            end
            CHECK: if (last_bit) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_wready    = (state == LOAD);
        ccff_shift_en = (state == SHIFT) || (state == CHECK);
        busy          = (state != IDLE);
        done          = (state == DONE);
        ccff_head     = 1'b0;
        if (state == SHIFT) begin
            ccff_head = shreg[0];
        end else if (state == CHECK) begin
            // Recirculate: a full rotation leaves the configuration intact.
            ccff_head = ccff_tail;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            word_bits <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt   <= '0;
                        word_bits <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_wvalid) begin
                        shreg     <= cfg_wdata;
                        word_bits <= WB_FULL;
                    end
                end
                SHIFT: begin
                    shreg     <= shreg >> 1;
                    word_bits <= word_bits - WB_ONE;
                    bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_ONE;
                end
                CHECK: begin
                    bit_cnt <= last_bit ? '0 : bit_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef CCFF_READBACK_CHECK_EN
    logic [15:0] crc_in;
    logic [15:0] crc_out;
    logic        error_q;

    ccff_crc16_serial u_crc_in (
        .clk     (prog_clk),
        .rst_n   (prog_rst_n),
        .clr     (start_acc),
        .en      (state == SHIFT),
        .bit_in  (ccff_head),
        .crc_out (crc_in)
    );

    ccff_crc16_serial u_crc_out (
        .clk     (prog_clk),
        .rst_n   (prog_rst_n),
        .clr     (start_acc),
        .en      (state == CHECK),
        .bit_in  (ccff_tail),
        .crc_out (crc_out)
    );

    // The final tail bit is absorbed on the same edge as the compare, so the
    // readback CRC is stepped once more here; error is then valid with done.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            error_q <= 1'b0;
        end else if (start_acc) begin
            error_q <= 1'b0;
        end else if ((state == CHECK) && last_bit &&
                     (crc16_step(crc_out, ccff_tail) != crc_in)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// tb_ccff_chain_loader
// Two loaders (16-bit and 12-bit chains, 8-bit words) each driving a model of
// a configuration chain. Directed steps plus randomized loads; expected head
// sequences and chain contents come from the word list, LSB-first.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam int LEN_A = 16;
    localparam int LEN_B = 12;
`ifdef CCFF_READBACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       prog_rst_n;
    logic [1:0] start_v;
    logic [7:0] cfg_wdata;
    logic       cfg_wvalid;
    logic [1:0] wready, head, shen, tail, busy, done, error;
    logic [2:0] dbg_a, dbg_b;

    ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(8)) dut_a (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_v[0]),
        .cfg_wdata(cfg_wdata), .cfg_wvalid(cfg_wvalid), .cfg_wready(wready[0]),
        .ccff_head(head[0]), .ccff_shift_en(shen[0]), .ccff_tail(tail[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .dbg_state(dbg_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(8)) dut_b (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_v[1]),
        .cfg_wdata(cfg_wdata), .cfg_wvalid(cfg_wvalid), .cfg_wready(wready[1]),
        .ccff_head(head[1]), .ccff_shift_en(shen[1]), .ccff_tail(tail[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .dbg_state(dbg_b)
    );

    // ---------------- chain models ----------------
    // chain[0] sits at the head, chain[LEN-1] drives the tail.
    logic [LEN_A-1:0] chain_a = '0;
    logic [LEN_B-1:0] chain_b = '0;
    logic [1:0]       en_s = '0;
    logic [1:0]       head_s = '0;
    logic             stuck7 = 1'b0;

    assign tail[0] = chain_a[LEN_A-1];
    assign tail[1] = chain_b[LEN_B-1];

    always @(posedge prog_clk) begin : chain_upd
        logic [LEN_A-1:0] na;
        if (en_s[0] === 1'b1) begin
            na = {chain_a[LEN_A-2:0], head_s[0]};
            if (stuck7) na[7] = 1'b0;
            chain_a <= na;
        end
        if (en_s[1] === 1'b1) chain_b <= {chain_b[LEN_B-2:0], head_s[1]};
    end

    // ---------------- monitor (negedge) ----------------
    int   obs_tot[2];
    int   done_tot[2];
    int   wready_tot[2];
    logic err_at_done[2];
    logic bit_mem[2][0:4095];

    initial begin
        for (int i = 0; i < 2; i++) begin
            obs_tot[i] = 0; done_tot[i] = 0; wready_tot[i] = 0; err_at_done[i] = 1'b0;
        end
    end

    always @(negedge prog_clk) begin
        en_s   = shen;
        head_s = head;
        for (int d = 0; d < 2; d++) begin
            if (shen[d] === 1'b1) begin
                if (obs_tot[d] < 4096) bit_mem[d][obs_tot[d]] = head[d];
                obs_tot[d]++;
            end
            if (done[d] === 1'b1) begin
                done_tot[d]++;
                err_at_done[d] = error[d];
            end
            if (wready[d] === 1'b1) wready_tot[d]++;
        end
    end

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         passed = 0;
    logic [7:0] wq[$];
    logic [31:0] last_obs[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge prog_clk);
        #1;
    endtask

    // Reference: concatenate words LSB-first, keep the first len bits.
    task automatic expect_bits(input int len, output logic [31:0] eb, output int n);
        eb = '0;
        n  = 0;
        foreach (wq[w]) begin
            for (int b = 0; b < 8; b++) begin
                if (n < len) begin
                    eb[n] = wq[w][b];
                    n++;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_load(input int d, input int gmin, input int gmax,
                            input bit start_mid, input bit stuck_case);
        int          len, n, k, base_obs, base_done, base_wr, exp_shifts;
        logic [31:0] eb, exp_obs, obs_v, exp_chain, act_chain;
        bit          gap_ok;
        len = (d == 0) ? LEN_A : LEN_B;
        expect_bits(len, eb, n);
        base_obs  = obs_tot[d];
        base_done = done_tot[d];
        base_wr   = wready_tot[d];

        start_v[d] = 1'b1;
        tick;
        start_v[d] = 1'b0;
        check("err_clr_on_start", {31'b0, error[d]}, 32'd0);

        gap_ok = 1'b1;
        foreach (wq[i]) begin
            k = 0;
            while (!wready[d] && busy[d] && k < 100) begin
                tick;
                k++;
            end
            if (!wready[d]) break;
            repeat ($urandom_range(gmin, gmax)) begin
                tick;
                if (shen[d] !== 1'b0 || wready[d] !== 1'b1) gap_ok = 1'b0;
            end
            cfg_wdata  = wq[i];
            cfg_wvalid = 1'b1;
            tick;
            cfg_wvalid = 1'b0;
            cfg_wdata  = 8'($urandom_range(0, 255));
            if (start_mid) begin
                start_v[d] = 1'b1;
                tick;
                start_v[d] = 1'b0;
            end
        end

        k = 0;
        while (done_tot[d] == base_done && k < 300) begin
            tick;
            k++;
        end
        check("done_seen", {31'b0, done_tot[d] != base_done}, 32'd1);
        repeat (3) tick;

        check("error_at_done", {31'b0, err_at_done[d]}, {31'b0, stuck_case & CHK});
        check("error_sticky", {31'b0, error[d]}, {31'b0, stuck_case & CHK});
        check("done_pulses", done_tot[d] - base_done, 32'd1);
        check("gap_quiet", {31'b0, gap_ok}, 32'd1);
        check("idle_outputs", {28'b0, busy[d], wready[d], shen[d], done[d]}, 32'd0);
        if (gmax == 0)
            check("wready_cycles", wready_tot[d] - base_wr, (len + 7) / 8);

        obs_v = '0;
        for (int i = 0; i < 32; i++)
            if (i < obs_tot[d] - base_obs) obs_v[i] = bit_mem[d][base_obs + i];
        last_obs[d] = obs_v;

        if (!stuck_case) begin
            exp_shifts = CHK ? 2 * len : len;
            exp_obs    = CHK ? (eb | (eb << len)) : eb;
            check("shift_cnt", obs_tot[d] - base_obs, exp_shifts);
            check("head_bits", obs_v, exp_obs);
            exp_chain = '0;
            for (int i = 0; i < len; i++) exp_chain[i] = eb[len - 1 - i];
            act_chain = (d == 0) ? {16'b0, chain_a} : {20'b0, chain_b};
            check("chain_contents", act_chain, exp_chain);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", passed, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int d, nw;
        prog_rst_n = 1'b0;
        start_v    = 2'b00;
        cfg_wvalid = 1'b0;
        cfg_wdata  = 8'h00;
        repeat (3) tick;

        // reset state
        check("rst_outputs_a", {26'b0, wready[0], head[0], shen[0], busy[0], done[0], error[0]}, 32'd0);
        check("rst_outputs_b", {26'b0, wready[1], head[1], shen[1], busy[1], done[1], error[1]}, 32'd0);
        check("rst_state_a", {29'b0, dbg_a}, {29'b0, IDLE});
        prog_rst_n = 1'b1;
        tick;

        // T1: basic load, explicit head pattern
        wq = '{8'hA5, 8'h3C};
        run_load(0, 0, 0, 1'b0, 1'b0);
        check("t1_pattern", {16'b0, last_obs[0][15:0]}, 32'h0000_3CA5);

        // T2: 12-bit chain, partial second word
        wq = '{8'hFF, 8'h0F};
        run_load(1, 0, 0, 1'b0, 1'b0);
        check("t2_pattern", {20'b0, last_obs[1][11:0]}, 32'h0000_0FFF);

        // T3: five idle LOAD cycles before each word
        wq = '{8'hA5, 8'h3C};
        run_load(0, 5, 5, 1'b0, 1'b0);

        // T4: start pulsed while shifting is ignored
        wq = '{8'hA5, 8'h3C};
        run_load(0, 0, 0, 1'b1, 1'b0);

        // T5: reset in the middle of SHIFT, then full reload
        begin
            int base, k;
            base = obs_tot[0];
            start_v[0] = 1'b1;
            tick;
            start_v[0] = 1'b0;
            cfg_wdata  = 8'hA5;
            cfg_wvalid = 1'b1;
            tick;
            cfg_wvalid = 1'b0;
            k = 0;
            while (obs_tot[0] - base < 5 && k < 50) begin
                tick;
                k++;
            end
            check("t5_reached_bit5", {31'b0, obs_tot[0] - base >= 5}, 32'd1);
            prog_rst_n = 1'b0;
            tick;
            check("t5_rst_outputs", {26'b0, wready[0], head[0], shen[0], busy[0], done[0], error[0]}, 32'd0);
            check("t5_rst_state", {29'b0, dbg_a}, {29'b0, IDLE});
            prog_rst_n = 1'b1;
            tick;
            wq = '{8'h5A, 8'hC3};
            run_load(0, 0, 0, 1'b0, 1'b0);
        end

        // T6: stuck-at-0 at chain bit 7 with all-ones data
        stuck7 = 1'b1;
        wq = '{8'hFF, 8'hFF};
        run_load(0, 0, 0, 1'b0, 1'b1);
        stuck7 = 1'b0;
        wq = '{8'h96, 8'h69};
        run_load(0, 0, 0, 1'b0, 1'b0);

        // randomized loads on both chains
        for (int r = 0; r < 8; r++) begin
            d  = r % 2;
            nw = ((d == 0) ? 2 : 2) + $urandom_range(0, 1);
            wq.delete();
            for (int i = 0; i < nw; i++) wq.push_back(8'($urandom_range(0, 255)));
            run_load(d, 0, (r < 4) ? 0 : 3, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
